// File: rtl/pic_inta_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge sequencer.
package pic_inta_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4,
    ACK3 = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [2:0] SPURIOUS_IR = 3'd7;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Registers the previous INTA level and reports falling/rising edges.
module inta_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic prev;

  // Reset to the idle (high) level so release from reset never fakes an edge.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) prev <= 1'b1;
    else          prev <= inta_n;
  end

  assign fall = prev & ~inta_n;
  assign rise = ~prev & inta_n;

endmodule

// File: rtl/inta_sequencer.sv
// INTA handshake controller: raises INT, counts INTA pulses, sets/clears ISR, drives vector bytes.
// Optional: define INTA_TIMEOUT_EN to abort a sequence stuck between INTA pulses.
module inta_sequencer
  import pic_inta_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int NUM_IR         = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inta_n,
  input  logic              int_req,
  input  logic [2:0]        chosen_ir,
  input  logic              mode_8086,
  input  logic              auto_eoi,
  input  logic [4:0]        vector_base,
  input  logic [2:0]        call_addr_lo,
  input  logic [7:0]        call_addr_hi,
  output logic              int_out,
  output logic              freeze,
  output logic [NUM_IR-1:0] isr_set,
  output logic [NUM_IR-1:0] isr_clr,
  output logic [7:0]        vector_out,
  output logic              vector_oe,
  output logic              busy,
  output logic              timeout_err
);

  state_t     state;
  logic [2:0] ir;
  logic       spurious;
  logic [1:0] pulse_cnt;
  logic       fall;
  logic       rise;
  logic       timeout_hit;

  inta_edge_detect u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .inta_n  (inta_n),
    .fall    (fall),
    .rise    (rise)
  );

`ifdef INTA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // Counts only while waiting in GAP; any INTA fall restarts it.
  always_ff @(posedge clock) begin
    if (!reset_n)           tcnt <= '0;
    else if (fall)          tcnt <= '0;
    else if (state == GAP)  tcnt <= tcnt + TW'(1);
  end

  assign timeout_hit = (state == GAP) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      ir          <= '0;
      spurious    <= 1'b0;
      pulse_cnt   <= '0;
      int_out     <= 1'b0;
      freeze      <= 1'b0;
      isr_set     <= '0;
      isr_clr     <= '0;
      vector_out  <= '0;
      vector_oe   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      isr_set     <= '0;
      isr_clr     <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (int_req) begin
          state   <= REQ;
          int_out <= 1'b1;
        end
        // INT stays up even if the request vanishes; the ack resolves it as spurious IR7.
        REQ: if (fall) begin
          state      <= ACK1;
          pulse_cnt  <= 2'd1;
          int_out    <= 1'b0;
          freeze     <= 1'b1;
          busy       <= 1'b1;
          vector_out <= CALL_OPCODE;
          vector_oe  <= !mode_8086;
          if (int_req) begin
            ir       <= chosen_ir;
            spurious <= 1'b0;
            isr_set  <= onehot8(chosen_ir);
          end else begin
            ir       <= SPURIOUS_IR;
            spurious <= 1'b1;
          end
        end
        ACK1: if (rise) begin
          state     <= GAP;
          vector_oe <= 1'b0;
        end
        GAP: if (fall) begin
          vector_oe <= 1'b1;
          if (pulse_cnt == 2'd1) begin
            state      <= ACK2;
            pulse_cnt  <= 2'd2;
            vector_out <= mode_8086 ? {vector_base, ir} : {call_addr_lo, ir, 2'b00};
          end else begin
            state      <= ACK3;
            pulse_cnt  <= 2'd3;
            vector_out <= call_addr_hi;
          end
        end else if (timeout_hit) begin
          // Abort leaves the ISR bit set; software clears it with an explicit EOI.
          state       <= IDLE;
          timeout_err <= 1'b1;
          vector_oe   <= 1'b0;
          freeze      <= 1'b0;
          busy        <= 1'b0;
        end
        ACK2: if (rise) begin
          vector_oe <= 1'b0;
          if (mode_8086) begin
            state  <= DONE;
            freeze <= 1'b0;
            busy   <= 1'b0;
            if (auto_eoi && !spurious) isr_clr <= onehot8(ir);
          end else begin
            state <= GAP;
          end
        end
        ACK3: if (rise) begin
          state     <= DONE;
          vector_oe <= 1'b0;
          freeze    <= 1'b0;
          busy      <= 1'b0;
          if (auto_eoi && !spurious) isr_clr <= onehot8(ir);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: vector table plus timeout and reset sequences.
module tb_inta_sequencer;

  localparam int TO = 10;

  logic       clock = 1'b0;
  logic       reset_n, inta_n, int_req, mode_8086, auto_eoi;
  logic [2:0] chosen_ir, call_addr_lo;
  logic [4:0] vector_base;
  logic [7:0] call_addr_hi;
  logic       int_out, freeze, vector_oe, busy, timeout_err;
  logic [7:0] isr_set, isr_clr, vector_out;

  int n_cmp = 0;
  int n_bad = 0;

  inta_sequencer #(.TIMEOUT_CYCLES(TO), .NUM_IR(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .inta_n       (inta_n),
    .int_req      (int_req),
    .chosen_ir    (chosen_ir),
    .mode_8086    (mode_8086),
    .auto_eoi     (auto_eoi),
    .vector_base  (vector_base),
    .call_addr_lo (call_addr_lo),
    .call_addr_hi (call_addr_hi),
    .int_out      (int_out),
    .freeze       (freeze),
    .isr_set      (isr_set),
    .isr_clr      (isr_clr),
    .vector_out   (vector_out),
    .vector_oe    (vector_oe),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       inta_n;
    logic       int_req;
    logic [2:0] ir;
    logic       m86;
    logic       aeoi;
    logic       e_int;
    logic       e_frz;
    logic       e_busy;
    logic [7:0] e_set;
    logic [7:0] e_clr;
    logic       e_oe;
    logic [7:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic in_n, input logic req, input logic [2:0] ir,
                              input logic m86, input logic ae, input logic ei, input logic ef,
                              input logic eb, input logic [7:0] es, input logic [7:0] ec,
                              input logic eo, input logic [7:0] ev);
    vec_t v;
    v.inta_n = in_n; v.int_req = req; v.ir = ir; v.m86 = m86; v.aeoi = ae;
    v.e_int = ei; v.e_frz = ef; v.e_busy = eb; v.e_set = es; v.e_clr = ec;
    v.e_oe = eo; v.e_vec = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ei, input logic ef, input logic eb,
                           input logic [7:0] es, input logic [7:0] ec, input logic eo,
                           input logic [7:0] ev);
    check({tag, ".int_out"}, 32'(int_out), 32'(ei));
    check({tag, ".freeze"}, 32'(freeze), 32'(ef));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".isr_set"}, 32'(isr_set), 32'(es));
    check({tag, ".isr_clr"}, 32'(isr_clr), 32'(ec));
    check({tag, ".vector_oe"}, 32'(vector_oe), 32'(eo));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(0));
    if (eo) check({tag, ".vector_out"}, 32'(vector_out), 32'(ev));
  endtask

  // One clock: inputs set before the rising edge, outputs sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int seen;
    int any_err;

    reset_n = 1'b0; inta_n = 1'b1; int_req = 1'b0; chosen_ir = 3'd0;
    mode_8086 = 1'b1; auto_eoi = 1'b0;
    vector_base = 5'h08; call_addr_lo = 3'b101; call_addr_hi = 8'h12;
    step(); step();
    check("reset.int_out", 32'(int_out), 0);
    check("reset.freeze", 32'(freeze), 0);
    check("reset.vector_oe", 32'(vector_oe), 0);
    check("reset.vector_out", 32'(vector_out), 0);
    check("reset.isr_set", 32'(isr_set), 0);
    check("reset.busy", 32'(busy), 0);
    reset_n = 1'b1;
    step();
    check("idle.int_out", 32'(int_out), 0);

    // 8086, base 08, IR3, no AEOI
    tbl.push_back(mk(1, 1, 3, 1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 1, 1, 8'h08, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 3, 1, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3, 1, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3, 1, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 3, 1, 0, 0, 1, 1, 8'h00, 8'h00, 1, 8'h43));
    tbl.push_back(mk(0, 0, 3, 1, 0, 0, 1, 1, 8'h00, 8'h00, 1, 8'h43));
    tbl.push_back(mk(1, 0, 3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    // 8080, lo=101, hi=12, IR2: CD, A8, 12
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 1, 1, 8'h04, 8'h00, 1, 8'hCD));
    tbl.push_back(mk(0, 0, 2, 0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 8'hCD));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 2, 0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 8'hA8));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 2, 0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 8'h12));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    // 8086 AEOI, IR6: set 40 on pulse 1, clear 40 in DONE
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 1, 6, 1, 1, 0, 1, 1, 8'h40, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 6, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 6, 1, 1, 0, 1, 1, 8'h00, 8'h00, 1, 8'h46));
    tbl.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 8'h00, 8'h40, 0, 8'h00));
    tbl.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    // Spurious: request drops while INT is up -> IR7, no set, no clear
    tbl.push_back(mk(1, 1, 5, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 5, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 5, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 5, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 0, 5, 1, 1, 0, 1, 1, 8'h00, 8'h00, 1, 8'h47));
    tbl.push_back(mk(1, 0, 5, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 5, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00));

    foreach (tbl[i]) begin
      inta_n = tbl[i].inta_n; int_req = tbl[i].int_req; chosen_ir = tbl[i].ir;
      mode_8086 = tbl[i].m86; auto_eoi = tbl[i].aeoi;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].e_int, tbl[i].e_frz, tbl[i].e_busy,
                tbl[i].e_set, tbl[i].e_clr, tbl[i].e_oe, tbl[i].e_vec);
    end

    // Stall after the first INTA pulse (8086, IR1, AEOI on)
    mode_8086 = 1'b1; auto_eoi = 1'b1; chosen_ir = 3'd1;
    int_req = 1'b1; inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    check("stall.isr_set", 32'(isr_set), 32'h02);
    int_req = 1'b0; inta_n = 1'b1; step();
    check("stall.gap_err", 32'(timeout_err), 0);
`ifdef INTA_TIMEOUT_EN
    seen = 0;
    any_err = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (isr_clr != 8'h00) any_err++;
      if (timeout_err) begin
        seen = k;
        check("timeout.freeze", 32'(freeze), 0);
        check("timeout.busy", 32'(busy), 0);
        check("timeout.vector_oe", 32'(vector_oe), 0);
        break;
      end
    end
    check("timeout.cycle", 32'(seen), 32'(TO));
    check("timeout.no_isr_clr", 32'(any_err), 0);
    step();
    check("timeout.pulse_width", 32'(timeout_err), 0);
    check("timeout.isr_clr", 32'(isr_clr), 0);
`else
    seen = 0;
    any_err = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (timeout_err) any_err++;
    end
    check("notimeout.err", 32'(any_err), 0);
    check("notimeout.busy", 32'(busy), 1);
    check("notimeout.freeze", 32'(freeze), 1);
    inta_n = 1'b0; step();
    check("notimeout.vector_oe", 32'(vector_oe), 1);
    check("notimeout.vector_out", 32'(vector_out), 32'h41);
    inta_n = 1'b1; step();
    check("notimeout.isr_clr", 32'(isr_clr), 32'h02);
    step();
`endif
    int_req = 1'b1; step();
    check("reidle.int_out", 32'(int_out), 1);

    // Reset during ACK2, then a stray INTA fall in IDLE
    chosen_ir = 3'd4; inta_n = 1'b0; step();
    check("rst.isr_set", 32'(isr_set), 32'h10);
    int_req = 1'b0; inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    check("rst.ack2_vector", 32'(vector_out), 32'h44);
    reset_n = 1'b0; step();
    check_all("rst.mid", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    check("rst.vector_out", 32'(vector_out), 0);
    reset_n = 1'b1; inta_n = 1'b1; step();
    check_all("rst.after", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    inta_n = 1'b0; step();
    check_all("rst.stray_fall", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    inta_n = 1'b1; step();
    check_all("rst.stray_rise", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
